matrix_input_ctrl: RTL

//   Sequences the UART token stream from the input decoder into one matrix slot of matrix storage.

---
 rtl/matrix_input_ctrl_pkg.sv | 40 ++++
 rtl/matrix_input_ctrl_if.sv | 34 +++
 rtl/matrix_input_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/matrix_input_ctrl_pkg.sv
// Shared constants, state/error encodings and element-range helper for matrix_input_ctrl.
// ELEM_MIN/ELEM_MAX bound elements when MAT_IN_RANGE_CHECK_EN is defined.
`ifndef ELEM_MIN
`define ELEM_MIN 0
`endif
`ifndef ELEM_MAX
`define ELEM_MAX 1000
`endif

package matrix_input_ctrl_pkg;
   localparam int unsigned MIC_MAX_DIM = 5;
   localparam int unsigned MIC_DATA_W  = 32;
   localparam int unsigned MIC_ADDR_W  = 8;
   localparam int unsigned MIC_CNT_W   = 5;

   localparam logic signed [MIC_DATA_W-1:0] MIC_ELEM_MIN = `ELEM_MIN;
   localparam logic signed [MIC_DATA_W-1:0] MIC_ELEM_MAX = `ELEM_MAX;

   typedef enum logic [2:0] {
      MIC_IDLE,
      MIC_GET_M,
      MIC_GET_N,
      MIC_GET_EL,
      MIC_PAD,
      MIC_DRAIN,
      MIC_DONE,
      MIC_ERR
   } mic_state_e;

   typedef enum logic [1:0] {
      MIC_ERR_NONE  = 2'd0,
      MIC_ERR_DIM   = 2'd1,
      MIC_ERR_EOL   = 2'd2,
      MIC_ERR_RANGE = 2'd3
   } mic_err_e;

   function automatic logic mic_in_range(input logic [MIC_DATA_W-1:0] v);
      return ($signed(v) >= MIC_ELEM_MIN) && ($signed(v) <= MIC_ELEM_MAX);
   endfunction
endpackage

// File: rtl/matrix_input_ctrl_if.sv
// Decoder-token, control and memory-write bundle around matrix_input_ctrl.
// master drives start/decoder tokens; slave is the controller.
interface matrix_input_ctrl_if
   import matrix_input_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = MIC_DATA_W,
   parameter int unsigned ADDR_W = MIC_ADDR_W
);
   logic              start;
   logic [ADDR_W-1:0] slot_base;
   logic [DATA_W-1:0] dec_int;
   logic              dec_data;
   logic              dec_space;
   logic              dec_newline;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mat_rows;
   logic [2:0]        mat_cols;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   modport master (
      output start, slot_base, dec_int, dec_data, dec_space, dec_newline,
      input  mem_we, mem_addr, mem_wdata, mat_rows, mat_cols, busy, done, err, err_code
   );

   modport slave (
      input  start, slot_base, dec_int, dec_data, dec_space, dec_newline,
      output mem_we, mem_addr, mem_wdata, mat_rows, mat_cols, busy, done, err, err_code
   );
endinterface

// File: rtl/matrix_input_ctrl.sv
// Parses "m n\n e0 e1 ...\n" decoder tokens into one matrix slot, row-major, zero-padded.
// Define MAT_IN_RANGE_CHECK_EN to abort on elements outside [ELEM_MIN, ELEM_MAX].
module matrix_input_ctrl
   import matrix_input_ctrl_pkg::*;
#(
   parameter int unsigned MAX_DIM = MIC_MAX_DIM,
   parameter int unsigned DATA_W  = MIC_DATA_W,
   parameter int unsigned ADDR_W  = MIC_ADDR_W,
   parameter int unsigned CNT_W   = MIC_CNT_W
) (
   input logic                clk,
   input logic                rst,
   matrix_input_ctrl_if.slave bus
);
   mic_state_e        r_state, w_state_d;
   mic_err_e          r_err_code, w_err_code_d;
   logic [ADDR_W-1:0] r_base, w_base_d;
   logic [2:0]        r_m, w_m_d;
   logic [2:0]        r_n, w_n_d;
   logic [CNT_W-1:0]  r_total, w_total_d;
   logic [CNT_W-1:0]  r_idx, w_idx_d;
   logic [CNT_W-1:0]  w_cnt;
   logic              r_we, w_we_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic [DATA_W-1:0] r_wdata, w_wdata_d;
   logic              w_dim_ok;
   logic              w_unused_space;

   assign w_unused_space = bus.dec_space;
   assign w_dim_ok = (bus.dec_int >= DATA_W'(1)) && (bus.dec_int <= DATA_W'(MAX_DIM));

   always_comb begin
      w_state_d    = r_state;
      w_err_code_d = r_err_code;
      w_base_d     = r_base;
      w_m_d        = r_m;
      w_n_d        = r_n;
      w_total_d    = r_total;
      w_idx_d      = r_idx;
      w_cnt        = r_idx;
      w_we_d       = 1'b0;
      w_addr_d     = r_addr;
      w_wdata_d    = r_wdata;
      unique case (r_state)
         MIC_IDLE: begin
            if (bus.start) begin
               w_base_d     = bus.slot_base;
               w_err_code_d = MIC_ERR_NONE;
               w_state_d    = MIC_GET_M;
            end
         end
         MIC_GET_M: begin
            // A newline right after m means the dimension line ended early.
            if (bus.dec_data) begin
               if (!w_dim_ok) begin
                  w_err_code_d = MIC_ERR_DIM;
                  w_state_d    = MIC_ERR;
               end else if (bus.dec_newline) begin
                  w_err_code_d = MIC_ERR_EOL;
                  w_state_d    = MIC_ERR;
               end else begin
                  w_m_d     = bus.dec_int[2:0];
                  w_state_d = MIC_GET_N;
               end
            end else if (bus.dec_newline) begin
               w_err_code_d = MIC_ERR_EOL;
               w_state_d    = MIC_ERR;
            end
         end
         MIC_GET_N: begin
            if (bus.dec_data) begin
               if (!w_dim_ok) begin
                  w_err_code_d = MIC_ERR_DIM;
                  w_state_d    = MIC_ERR;
               end else begin
                  w_n_d     = bus.dec_int[2:0];
                  w_total_d = CNT_W'(r_m) * CNT_W'(bus.dec_int[2:0]);
                  w_idx_d   = '0;
                  w_state_d = MIC_GET_EL;
               end
            end else if (bus.dec_newline) begin
               w_err_code_d = MIC_ERR_EOL;
               w_state_d    = MIC_ERR;
            end
         end
         MIC_GET_EL: begin
            if (bus.dec_data) begin
`ifdef MAT_IN_RANGE_CHECK_EN
               if (!mic_in_range(bus.dec_int)) begin
                  w_err_code_d = MIC_ERR_RANGE;
                  w_state_d    = MIC_ERR;
               end else
`endif
               begin
                  w_we_d    = 1'b1;
                  w_addr_d  = r_base + ADDR_W'(r_idx);
                  w_wdata_d = bus.dec_int;
                  w_cnt     = r_idx + 1'b1;
               end
            end
            w_idx_d = w_cnt;
            // Newline is judged against the count after any same-cycle element.
            if (w_state_d == MIC_GET_EL) begin
               if (bus.dec_newline && (w_cnt != '0)) begin
                  w_state_d = (w_cnt == r_total) ? MIC_DONE : MIC_PAD;
               end else if (w_cnt == r_total) begin
                  w_state_d = MIC_DRAIN;
               end
            end
         end
         MIC_PAD: begin
            w_we_d    = 1'b1;
            w_addr_d  = r_base + ADDR_W'(r_idx);
            w_wdata_d = '0;
            w_idx_d   = r_idx + 1'b1;
            if (w_idx_d == r_total) begin
               w_state_d = MIC_DONE;
            end
         end
         MIC_DRAIN: begin
            if (bus.dec_newline) begin
               w_state_d = MIC_DONE;
            end
         end
         MIC_DONE: w_state_d = MIC_IDLE;
         MIC_ERR:  w_state_d = MIC_IDLE;
         default:  w_state_d = MIC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= MIC_IDLE;
         r_err_code <= MIC_ERR_NONE;
         r_base     <= '0;
         r_m        <= '0;
         r_n        <= '0;
         r_total    <= '0;
         r_idx      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state    <= w_state_d;
         r_err_code <= w_err_code_d;
         r_base     <= w_base_d;
         r_m        <= w_m_d;
         r_n        <= w_n_d;
         r_total    <= w_total_d;
         r_idx      <= w_idx_d;
         r_we       <= w_we_d;
         r_addr     <= w_addr_d;
         r_wdata    <= w_wdata_d;
      end
   end

   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mat_rows  = r_m;
   assign bus.mat_cols  = r_n;
   assign bus.err_code  = r_err_code;
   assign bus.done      = (r_state == MIC_DONE);
   assign bus.err       = (r_state == MIC_ERR);
   assign bus.busy      = (r_state != MIC_IDLE) && (r_state != MIC_DONE) && (r_state != MIC_ERR);
endmodule
